if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues one outstanding word request per PC value, queues
// {pc, instr} pairs toward ID and steers the PC register on advance/redirect.
module if_fetch_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        en_pc,
    output logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               req_q;
    logic [31:0]        addr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]        fifo_instr_q [FIFO_DEPTH];
    logic [31:0]        id_pc_q, id_pc_d;
    logic [31:0]        id_instr_q, id_instr_d;

    logic               pop;
    logic               space;
    logic [CNT_W-1:0]   cnt_after_pop;
    logic               issue;
    logic               push;
    logic               retire;
    logic               head_load;

    assign id_valid      = (count_q != '0);
    assign pop           = id_valid & id_ready;
    assign cnt_after_pop = count_q - CNT_W'(pop);
    assign space         = (cnt_after_pop < CNT_W'(FIFO_DEPTH));

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!redirect && space) state_d = BUSY;
            end
            BUSY: begin
                if (imem_ack)      state_d = IDLE;
                else if (redirect) state_d = DRAIN;
            end
            DRAIN: begin
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A redirect makes the current pc stale, so no request is issued that cycle.
    always_comb begin
        issue  = (state_q == IDLE) & ~redirect & space;
        push   = (state_q == BUSY) & imem_ack & ~redirect;
        retire = (state_q != IDLE) & imem_ack;
        en_pc  = ~reset & (redirect | ((state_q == BUSY) & imem_ack));
        npc    = redirect ? redirect_target : pc + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q  <= 1'b0;
            addr_q <= '0;
        end else if (issue) begin
            req_q  <= 1'b1;
            addr_q <= pc;
        end else if (retire) begin
            req_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= addr_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // The head is registered so id_* keep their last value once the queue empties.
    always_comb begin
        count_d    = cnt_after_pop + CNT_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        head_load  = 1'b0;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else if (count_d != '0) begin
            head_load = 1'b1;
        end
        if (head_load) begin
            if (cnt_after_pop == '0) begin
                id_pc_d    = addr_q;
                id_instr_d = imem_rdata;
            end else begin
                id_pc_d    = fifo_pc_q[rd_ptr_d];
                id_instr_d = fifo_instr_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            id_pc_q    <= '0;
            id_instr_q <= '0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written reset/wrap
// sequences, then random traffic against a queue-based reference model.
module tb_if_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        en_pc;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;

    int vectors = 0;
    int errors  = 0;

    if_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .en_pc(en_pc), .npc(npc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_target(redirect_target), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ack;
        logic        redir;
        logic [31:0] tgt;
        logic        rdy;
        logic        en;
        logic [31:0] npc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] idpc;
    } vec_t;

    vec_t tbl [19];

    // Reference model state: outstanding request, whether its data is wanted,
    // the ID queue and the last head shown on id_*.
    logic        m_busy, m_want;
    logic [31:0] m_addr, m_pc, m_hpc, m_hin;
    logic [31:0] q_pc [$];
    logic [31:0] q_in [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic apply_reset();
        reset = 1'b1; redirect = 1'b0; imem_ack = 1'b0; id_ready = 1'b0; pc = '0;
        @(negedge clk);
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_vld", id_valid, 1'b0);
        chk("rst_idpc", id_pc, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_en", en_pc, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_want = 1'b0; m_addr = '0; m_hpc = '0; m_hin = '0;
        q_pc.delete(); q_in.delete();
    endtask

    task automatic rand_cycle();
        logic        e_en, e_vld, do_pop, do_push, do_issue;
        logic [31:0] e_npc;
        int          sz;
        redirect        = ($urandom_range(0, 7) == 0);
        redirect_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        imem_ack        = 1'($urandom_range(0, 1));
        id_ready        = ($urandom_range(0, 2) != 0);
        pc              = m_pc;
        imem_rdata      = memf(m_addr);
        #1;
        e_vld = (q_pc.size() != 0);
        e_en  = redirect | (m_busy & m_want & imem_ack);
        e_npc = redirect ? redirect_target : m_pc + 32'd4;
        chk("r_en", en_pc, e_en);
        chk("r_npc", npc, e_npc);
        chk("r_req", imem_req, m_busy);
        chk("r_addr", imem_addr, m_addr);
        chk("r_vld", id_valid, e_vld);
        chk("r_idpc", id_pc, e_vld ? q_pc[0] : m_hpc);
        chk("r_instr", id_instr, e_vld ? q_in[0] : m_hin);
        do_pop  = e_vld & id_ready;
        do_push = m_busy & m_want & imem_ack & ~redirect;
        sz = q_pc.size();
        if (do_pop) sz--;
        do_issue = ~m_busy & ~redirect & (sz < DEPTH);
        if (redirect) begin
            q_pc.delete(); q_in.delete();
        end else begin
            if (do_pop) begin
                void'(q_pc.pop_front()); void'(q_in.pop_front());
            end
            if (do_push) begin
                q_pc.push_back(m_addr); q_in.push_back(imem_rdata);
            end
        end
        if (m_busy && imem_ack) m_busy = 1'b0;
        else if (m_busy && redirect) m_want = 1'b0;
        else if (do_issue) begin
            m_busy = 1'b1; m_want = 1'b1; m_addr = m_pc;
        end
        if (e_en) m_pc = e_npc;
        if (q_pc.size() != 0) begin
            m_hpc = q_pc[0]; m_hin = q_in[0];
        end
        @(negedge clk);
    endtask

    initial begin
        //          pc            ack redir tgt           rdy   en  npc           req addr          vld idpc
        tbl[0]  = '{32'h00003000, 1, 0, 32'h0,        1,    0, 32'h00003004, 0, 32'h00000000, 0, 32'h00000000};
        tbl[1]  = '{32'h00003000, 1, 0, 32'h0,        1,    1, 32'h00003004, 1, 32'h00003000, 0, 32'h00000000};
        tbl[2]  = '{32'h00003004, 0, 0, 32'h0,        1,    0, 32'h00003008, 0, 32'h00003000, 1, 32'h00003000};
        tbl[3]  = '{32'h00003004, 1, 0, 32'h0,        1,    1, 32'h00003008, 1, 32'h00003004, 0, 32'h00003000};
        tbl[4]  = '{32'h00003008, 0, 0, 32'h0,        0,    0, 32'h0000300C, 0, 32'h00003004, 1, 32'h00003004};
        tbl[5]  = '{32'h00003008, 1, 0, 32'h0,        0,    1, 32'h0000300C, 1, 32'h00003008, 1, 32'h00003004};
        tbl[6]  = '{32'h0000300C, 0, 0, 32'h0,        0,    0, 32'h00003010, 0, 32'h00003008, 1, 32'h00003004};
        tbl[7]  = '{32'h0000300C, 0, 0, 32'h0,        0,    0, 32'h00003010, 0, 32'h00003008, 1, 32'h00003004};
        tbl[8]  = '{32'h0000300C, 0, 0, 32'h0,        1,    0, 32'h00003010, 0, 32'h00003008, 1, 32'h00003004};
        tbl[9]  = '{32'h0000300C, 0, 0, 32'h0,        0,    0, 32'h00003010, 1, 32'h0000300C, 1, 32'h00003008};
        tbl[10] = '{32'h0000300C, 0, 1, 32'h00003100, 0,    1, 32'h00003100, 1, 32'h0000300C, 1, 32'h00003008};
        tbl[11] = '{32'h00003100, 0, 0, 32'h0,        0,    0, 32'h00003104, 1, 32'h0000300C, 0, 32'h00003008};
        tbl[12] = '{32'h00003100, 1, 0, 32'h0,        0,    0, 32'h00003104, 1, 32'h0000300C, 0, 32'h00003008};
        tbl[13] = '{32'h00003100, 1, 0, 32'h0,        0,    0, 32'h00003104, 0, 32'h0000300C, 0, 32'h00003008};
        tbl[14] = '{32'h00003100, 1, 1, 32'h00003200, 0,    1, 32'h00003200, 1, 32'h00003100, 0, 32'h00003008};
        tbl[15] = '{32'h00003200, 0, 0, 32'h0,        0,    0, 32'h00003204, 0, 32'h00003100, 0, 32'h00003008};
        tbl[16] = '{32'h00003200, 0, 0, 32'h0,        1,    0, 32'h00003204, 1, 32'h00003200, 0, 32'h00003008};
        tbl[17] = '{32'h00003200, 1, 0, 32'h0,        1,    1, 32'h00003204, 1, 32'h00003200, 0, 32'h00003008};
        tbl[18] = '{32'h00003204, 0, 0, 32'h0,        1,    0, 32'h00003208, 0, 32'h00003200, 1, 32'h00003200};

        apply_reset();
        for (int i = 0; i < 19; i++) begin
            pc              = tbl[i].pc;
            imem_ack        = tbl[i].ack;
            redirect        = tbl[i].redir;
            redirect_target = tbl[i].tgt;
            id_ready        = tbl[i].rdy;
            imem_rdata      = ~tbl[i].addr;
            #1;
            chk($sformatf("t%0d_en", i), en_pc, tbl[i].en);
            chk($sformatf("t%0d_npc", i), npc, tbl[i].npc);
            chk($sformatf("t%0d_req", i), imem_req, tbl[i].req);
            chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("t%0d_vld", i), id_valid, tbl[i].vld);
            chk($sformatf("t%0d_idpc", i), id_pc, tbl[i].idpc);
            if (tbl[i].vld) chk($sformatf("t%0d_instr", i), id_instr, ~tbl[i].idpc);
            @(negedge clk);
        end

        // Wrap-around of the sequential PC.
        apply_reset();
        redirect = 1'b0; id_ready = 1'b0; imem_ack = 1'b0; pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_npc_idle", npc, 32'h0000_0000);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
        #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_en", en_pc, 1'b1);
        chk("wrap_npc", npc, 32'h0000_0000);
        @(negedge clk);
        imem_ack = 1'b0; pc = 32'h0000_0000;
        #1;
        chk("wrap_vld", id_valid, 1'b1);
        chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", id_instr, 32'h0BAD_F00D);
        @(negedge clk);

        // Asynchronous reset between edges while a request is outstanding.
        apply_reset();
        pc = 32'h0000_5000; imem_ack = 1'b0; id_ready = 1'b0; imem_rdata = 32'h1111_2222;
        @(negedge clk);
        imem_ack = 1'b1;
        #1;
        chk("ar_en_ack", en_pc, 1'b1);
        @(negedge clk);
        imem_ack = 1'b0; pc = 32'h0000_5004;
        #1;
        chk("ar_vld_pre", id_valid, 1'b1);
        @(negedge clk);
        #1;
        chk("ar_req_pre", imem_req, 1'b1);
        imem_ack = 1'b1;
        #1;
        chk("ar_en_pre", en_pc, 1'b1);
        reset = 1'b1;
        #1;
        chk("ar_req", imem_req, 1'b0);
        chk("ar_vld", id_valid, 1'b0);
        chk("ar_en", en_pc, 1'b0);
        chk("ar_idpc", id_pc, 32'h0);
        imem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar_req_rel", imem_req, 1'b0);
        @(negedge clk);
        #1;
        chk("ar_req_new", imem_req, 1'b1);
        chk("ar_addr_new", imem_addr, 32'h0000_5004);
        @(negedge clk);

        // Random traffic against the reference model.
        apply_reset();
        model_reset();
        m_pc = $urandom & 32'hFFFF_FFFC;
        for (int n = 0; n < 3000; n++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
